// File: rtl/main_pkg.sv
// Shared constants for the transducer-drive core: default sizes, bus table selects
// and control-register indices.
package main_pkg;

  localparam int unsigned MAIN_WIDTH = 13;
  localparam int unsigned MAIN_DEPTH = 249;
  localparam int unsigned CYCLE_RST  = 4096;

  localparam logic [1:0] SEL_CTL   = 2'd0;
  localparam logic [1:0] SEL_CYCLE = 2'd1;
  localparam logic [1:0] SEL_DUTY  = 2'd2;
  localparam logic [1:0] SEL_PHASE = 2'd3;

  localparam logic [7:0] CTL_FAN  = 8'd0;
  localparam logic [7:0] CTL_SYNC = 8'd1;

  typedef logic [MAIN_WIDTH-1:0] value_t;

endpackage

// File: rtl/pwm_channel.sv
// One PWM channel: period counter with sync reset, shadowed duty/phase, and a
// registered phase-shifted compare.
module pwm_channel #(
  parameter int unsigned Width = 13
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             sync_i,
  input  logic [Width-1:0] cycle_i,
  input  logic [Width-1:0] duty_i,
  input  logic [Width-1:0] phase_i,
  output logic             pwm_o
);

  localparam int unsigned W1 = Width + 1;

  logic [Width-1:0] t_q, t_d;
  logic [Width-1:0] duty_s_q, phase_s_q;
  logic             pwm_q, pwm_d;
  logic             enable, at_end, load;
  logic [W1-1:0]    cyc_w, t_w, ph_w, d_w;

  always_comb begin
    cyc_w  = {1'b0, cycle_i};
    t_w    = {1'b0, t_q};
    enable = cycle_i > Width'(1);
    // >= rather than == so a cycle shrunk below the running count still wraps
    at_end = enable && (t_w >= cyc_w - W1'(1));
    load   = sync_i || at_end;

    if (!enable || sync_i || at_end) begin
      t_d = '0;
    end else begin
      t_d = t_q + Width'(1);
    end

    ph_w = {1'b0, phase_s_q};
    if (ph_w >= cyc_w) begin
      ph_w = ph_w - cyc_w;
    end
    if (t_w >= ph_w) begin
      d_w = t_w - ph_w;
    end else begin
      d_w = t_w + cyc_w - ph_w;
    end
    pwm_d = enable && (d_w < {1'b0, duty_s_q});
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      t_q       <= '0;
      duty_s_q  <= '0;
      phase_s_q <= '0;
      pwm_q     <= 1'b0;
    end else begin
      t_q   <= t_d;
      pwm_q <= pwm_d;
      if (load) begin
        duty_s_q  <= duty_i;
        phase_s_q <= phase_i;
      end
    end
  end

  assign pwm_o = pwm_q;

endmodule

// File: rtl/fpga_main_core.sv
// Transducer-drive top: cycle/duty/phase tables on a CPU register bus, SYNC0
// synchronizer and edge detect, fan-force logic, and one PWM channel per transducer.
module fpga_main_core
  import main_pkg::*;
#(
  parameter int unsigned WIDTH = MAIN_WIDTH,
  parameter int unsigned DEPTH = MAIN_DEPTH
) (
  input  logic             CLK,
  input  logic             RST_N,
  input  logic             CAT_SYNC0,
  input  logic             BUS_EN,
  input  logic             BUS_WE,
  input  logic [9:0]       BUS_ADDR,
  input  logic [15:0]      BUS_DIN,
  output logic [15:0]      BUS_DOUT,
  input  logic             THERMO,
  output logic             FORCE_FAN,
  output logic [DEPTH-1:0] PWM_OUT
);

  logic [WIDTH-1:0] cycle_q [DEPTH];
  logic [WIDTH-1:0] duty_q  [DEPTH];
  logic [WIDTH-1:0] phase_q [DEPTH];
  logic             fan_en_q;
  logic [2:0]       sync_q;
  logic [15:0]      dout_q, rd_data;
  logic [1:0]       sel;
  logic [7:0]       idx;
  logic             idx_ok, wr, rd, sync_pulse;
  logic             unused_din;

  assign sel        = BUS_ADDR[9:8];
  assign idx        = BUS_ADDR[7:0];
  assign idx_ok     = {24'd0, idx} < DEPTH;
  assign wr         = BUS_EN && BUS_WE;
  assign rd         = BUS_EN && !BUS_WE;
  assign unused_din = ^BUS_DIN[15:WIDTH];

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      for (int i = 0; i < DEPTH; i++) begin
        cycle_q[i] <= WIDTH'(CYCLE_RST);
        duty_q[i]  <= '0;
        phase_q[i] <= '0;
      end
    end else if (wr && idx_ok) begin
      case (sel)
        SEL_CYCLE: cycle_q[idx] <= BUS_DIN[WIDTH-1:0];
        SEL_DUTY:  duty_q[idx]  <= BUS_DIN[WIDTH-1:0];
        SEL_PHASE: phase_q[idx] <= BUS_DIN[WIDTH-1:0];
        default: ;
      endcase
    end
  end

  always_comb begin
    rd_data = '0;
    if (idx_ok) begin
      unique case (sel)
        SEL_CTL: begin
          if (idx == CTL_FAN) begin
            rd_data[0] = fan_en_q;
          end else if (idx == CTL_SYNC) begin
            rd_data[0] = sync_q[1];
          end
        end
        SEL_CYCLE: rd_data[WIDTH-1:0] = cycle_q[idx];
        SEL_DUTY:  rd_data[WIDTH-1:0] = duty_q[idx];
        SEL_PHASE: rd_data[WIDTH-1:0] = phase_q[idx];
      endcase
    end
  end

  // sync_q[1:0] is the two-flop synchronizer, sync_q[2] the previous synced level
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      fan_en_q <= 1'b0;
      sync_q   <= '0;
      dout_q   <= '0;
    end else begin
      sync_q <= {sync_q[1:0], CAT_SYNC0};
      if (wr && sel == SEL_CTL && idx == CTL_FAN) begin
        fan_en_q <= BUS_DIN[0];
      end
      if (rd) begin
        dout_q <= rd_data;
      end
    end
  end

  assign sync_pulse = sync_q[1] && !sync_q[2];
  assign BUS_DOUT   = dout_q;
  assign FORCE_FAN  = THERMO || fan_en_q;

  for (genvar i = 0; i < DEPTH; i++) begin : g_ch
    pwm_channel #(
      .Width(WIDTH)
    ) u_ch (
      .clk_i  (CLK),
      .rst_ni (RST_N),
      .sync_i (sync_pulse),
      .cycle_i(cycle_q[i]),
      .duty_i (duty_q[i]),
      .phase_i(phase_q[i]),
      .pwm_o  (PWM_OUT[i])
    );
  end

endmodule

// File: tb/tb_fpga_main_core.sv
// Scoreboarded bench for fpga_main_core: bus reads are checked by a monitor, PWM
// waveforms are scanned per period against hand-derived on-windows.
module tb_fpga_main_core;
  import main_pkg::*;

  logic         CLK = 1'b0;
  logic         RST_N;
  logic         CAT_SYNC0;
  logic         BUS_EN;
  logic         BUS_WE;
  logic [9:0]   BUS_ADDR;
  logic [15:0]  BUS_DIN;
  logic [15:0]  BUS_DOUT;
  logic         THERMO;
  logic         FORCE_FAN;
  logic [248:0] PWM_OUT;

  fpga_main_core u_dut (
    .CLK      (CLK),
    .RST_N    (RST_N),
    .CAT_SYNC0(CAT_SYNC0),
    .BUS_EN   (BUS_EN),
    .BUS_WE   (BUS_WE),
    .BUS_ADDR (BUS_ADDR),
    .BUS_DIN  (BUS_DIN),
    .BUS_DOUT (BUS_DOUT),
    .THERMO   (THERMO),
    .FORCE_FAN(FORCE_FAN),
    .PWM_OUT  (PWM_OUT)
  );

  always #5 CLK = ~CLK;

  typedef struct {
    string       name;
    logic [15:0] exp;
  } item_t;

  item_t sb_q[$];
  int    checks   = 0;
  int    failures = 0;
  logic  rd_pend;

  function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0d required=%0d", name, act, exp);
    end
  endfunction

  // Monitor: a read response is valid one cycle after a read strobe
  always @(posedge CLK or negedge RST_N) begin
    if (!RST_N) rd_pend <= 1'b0;
    else        rd_pend <= BUS_EN && !BUS_WE;
  end

  always @(negedge CLK) begin
    if (rd_pend) begin
      if (sb_q.size() == 0) begin
        chk("sb_unexpected_read", 1, 0);
      end else begin
        item_t it;
        it = sb_q.pop_front();
        chk(it.name, {16'd0, BUS_DOUT}, {16'd0, it.exp});
      end
    end
  end

  task automatic bus_write(input logic [1:0] sel, input logic [7:0] idx, input logic [15:0] d);
    BUS_EN = 1'b1; BUS_WE = 1'b1; BUS_ADDR = {sel, idx}; BUS_DIN = d;
    @(negedge CLK);
    BUS_EN = 1'b0; BUS_WE = 1'b0;
  endtask

  task automatic bus_read(input logic [1:0] sel, input logic [7:0] idx, input logic [15:0] exp,
                          input string name);
    item_t it;
    it.name = name;
    it.exp  = exp;
    sb_q.push_back(it);
    BUS_EN = 1'b1; BUS_WE = 1'b0; BUS_ADDR = {sel, idx};
    @(negedge CLK);
    BUS_EN = 1'b0;
    @(negedge CLK);
  endtask

  function automatic logic exp_pwm(input int ch, input int t, input int d3);
    case (ch)
      3:       return t < d3;
      7:       return (t >= 4000) || (t < 104);
      10:      return 1'b1;
      default: return 1'b0;
    endcase
  endfunction

  // Called at the negedge where PWM_OUT reflects t=0; returns at the next period's t=0
  task automatic scan(input int p, input int d3, input int wr_t);
    int chs[5] = '{3, 7, 10, 11, 12};
    int err[5] = '{0, 0, 0, 0, 0};
    for (int t = 0; t < 4096; t++) begin
      if (t == wr_t) begin
        BUS_EN = 1'b1; BUS_WE = 1'b1; BUS_ADDR = {SEL_DUTY, 8'd3}; BUS_DIN = 16'd1000;
      end else if (t == wr_t + 1) begin
        BUS_EN = 1'b0; BUS_WE = 1'b0;
      end
      for (int k = 0; k < 5; k++) begin
        if (PWM_OUT[chs[k]] !== exp_pwm(chs[k], t, d3)) err[k]++;
      end
      @(negedge CLK);
    end
    for (int k = 0; k < 5; k++) begin
      chk($sformatf("scan%0d_ch%0d_bad_cycles", p, chs[k]), err[k], 0);
    end
  endtask

  initial begin
    RST_N = 1'b0; CAT_SYNC0 = 1'b0; THERMO = 1'b0;
    BUS_EN = 1'b0; BUS_WE = 1'b0; BUS_ADDR = '0; BUS_DIN = '0;
    repeat (3) @(negedge CLK);
    chk("rst_pwm_any", {31'd0, |PWM_OUT}, 0);
    chk("rst_force_fan", {31'd0, FORCE_FAN}, 0);
    chk("rst_bus_dout", {16'd0, BUS_DOUT}, 0);
    THERMO = 1'b1;
    #1 chk("rst_force_fan_thermo", {31'd0, FORCE_FAN}, 1);
    THERMO = 1'b0;
    @(negedge CLK);
    RST_N = 1'b1;
    @(negedge CLK);

    bus_read(SEL_CYCLE, 8'd0, 16'd4096, "rd_cycle0_rst");
    bus_read(SEL_CYCLE, 8'd248, 16'd4096, "rd_cycle248_rst");
    bus_read(SEL_DUTY, 8'd5, 16'd0, "rd_duty5_rst");
    bus_read(SEL_CTL, CTL_SYNC, 16'd0, "rd_sync_low");

    bus_write(SEL_CYCLE, 8'd3, 16'd4096);
    bus_write(SEL_DUTY, 8'd3, 16'd2048);
    bus_write(SEL_PHASE, 8'd3, 16'd0);
    bus_write(SEL_PHASE, 8'd7, 16'd4000);
    bus_write(SEL_DUTY, 8'd7, 16'd200);
    bus_write(SEL_DUTY, 8'd10, 16'd4096);
    bus_write(SEL_DUTY, 8'd11, 16'd0);
    bus_write(SEL_CYCLE, 8'd12, 16'd1);
    bus_write(SEL_DUTY, 8'd12, 16'd5);
    bus_write(SEL_DUTY, 8'd249, 16'd123);
    bus_write(SEL_CTL, 8'd2, 16'hffff);

    bus_read(SEL_DUTY, 8'd3, 16'd2048, "rd_duty3");
    bus_write(SEL_DUTY, 8'd5, 16'd77);
    chk("dout_hold_after_write", {16'd0, BUS_DOUT}, 2048);
    bus_read(SEL_PHASE, 8'd7, 16'd4000, "rd_phase7");
    bus_read(SEL_CYCLE, 8'd12, 16'd1, "rd_cycle12");
    bus_read(SEL_DUTY, 8'd249, 16'd0, "rd_duty249_oob");
    bus_read(SEL_CYCLE, 8'd255, 16'd0, "rd_cycle255_oob");
    bus_read(SEL_CTL, 8'd2, 16'd0, "rd_ctl2");
    bus_read(SEL_DUTY, 8'd5, 16'd77, "rd_duty5_new");

    // First SYNC0 edge: t=0 reaches the pins on the fourth negedge
    CAT_SYNC0 = 1'b1;
    repeat (4) @(negedge CLK);
    scan(0, 2048, 1000);
    scan(1, 1000, -10);
    bus_read(SEL_CTL, CTL_SYNC, 16'd1, "rd_sync_high");

    // Second edge lands mid-period and must realign every channel
    CAT_SYNC0 = 1'b0;
    repeat (500) @(negedge CLK);
    CAT_SYNC0 = 1'b1;
    repeat (4) @(negedge CLK);
    scan(2, 1000, -10);

    THERMO = 1'b1;
    #1 chk("fan_thermo", {31'd0, FORCE_FAN}, 1);
    @(negedge CLK);
    THERMO = 1'b0;
    #1 chk("fan_off", {31'd0, FORCE_FAN}, 0);
    @(negedge CLK);
    bus_write(SEL_CTL, CTL_FAN, 16'd1);
    chk("fan_en", {31'd0, FORCE_FAN}, 1);
    bus_read(SEL_CTL, CTL_FAN, 16'd1, "rd_fan_en");
    bus_read(SEL_DUTY, 8'd10, 16'd4096, "rd_duty10");

    // Asynchronous reset in the middle of a cycle
    #2 RST_N = 1'b0;
    #1;
    chk("midrst_pwm_any", {31'd0, |PWM_OUT}, 0);
    chk("midrst_bus_dout", {16'd0, BUS_DOUT}, 0);
    chk("midrst_force_fan", {31'd0, FORCE_FAN}, 0);
    @(negedge CLK);
    RST_N = 1'b1;
    @(negedge CLK);
    bus_read(SEL_DUTY, 8'd3, 16'd0, "rd_duty3_after_rst");
    bus_read(SEL_CYCLE, 8'd12, 16'd4096, "rd_cycle12_after_rst");

    for (int i = 0; i < 10 && sb_q.size() != 0; i++) @(negedge CLK);
    chk("sb_drain", sb_q.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
